alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execution-side responder for the reservation-station dispatch interface.
- Accepts one operation at a time (ALU_ready, LV, RV, Op) and computes it. Returns a one-cycle ALU_success pulse with result.
- Holds busy high while an operation is in flight, so the RS keeps its request stable.
- Shifts are iterative, 1 bit/cycle; all other ops take a fixed 1 cycle.

Parameters:
- XLEN, 32, datapath width
- OP_W, 4, opcode width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes the block
- flush  in  1  synchronous kill: abort in-flight op, suppress its ALU_success
- ALU_ready  in  1  request valid from RS
- LV  in  XLEN  left operand
- RV  in  XLEN  right operand; shift amount = RV[4:0]
- Op  in  OP_W  operation code
- busy  out  1  high while an op is in flight (state != IDLE)
- ALU_success  out  1  one-cycle result-valid pulse
- result  out  XLEN  result; holds until next ALU_success

Behaviour:
- Op encodings: Add=0, Minus=1, And=2, Or=3, Xor=4, LeftShift=5, RightShift=6, RightShift_A=7, Less=8 (signed), GEQ=9 (signed), Equal=10, NotEqual=11, LessU=12, GEQU=13. Codes 14-15 yield result 0 and still pulse ALU_success.
- Compare ops return 32'd1 or 32'd0. Add/Minus wrap mod 2^XLEN, with no overflow flag.
- Reset (asynchronous, any time, including mid-operation): state=IDLE, busy=0, ALU_success=0, result=0, operand and count registers=0.
- States: IDLE, COMPUTE, SHIFT.
- IDLE: at an edge with rdy && ALU_ready && !flush, capture LV, RV, Op.
  - Shift op with RV[4:0]!=0: go to SHIFT; cnt=RV[4:0]; acc=LV.
  - Otherwise: go to COMPUTE.
  - Requests arriving while busy=1 are ignored; the RS must hold ALU_ready.
- COMPUTE: next edge registers the result, sets ALU_success=1 and returns to IDLE.
- SHIFT: each edge shifts acc by 1 (logical left, logical right, or arithmetic right) and decrements cnt.
  - At the edge where cnt==1: result=final acc, ALU_success=1, return to IDLE.
- Latency from capture edge E0 to ALU_success visible: 1 edge for non-shift ops and shamt=0; shamt edges otherwise (max 31).
- ALU_success is deasserted at every edge where it is not being set, so it is exactly 1 cycle wide.
- Throughput: a new request can be captured at the same edge after which ALU_success is high. Minimum spacing is 2 cycles per op.
- flush=1 at an edge: state goes to IDLE, ALU_success goes to 0, and no capture occurs. flush has priority over completion in the same cycle. result keeps its previous value.
- rdy=0: all registers hold, including ALU_success. flush and requests are ignored while rdy=0.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- When defined: shifts use the COMPUTE path with a combinational barrel shifter, so every op has 1-edge latency and the SHIFT state is never entered.
- When undefined: iterative SHIFT behaviour as described above.

Test Plan:
- Reset/add: assert rst mid-SHIFT -> busy=0, ALU_success=0, result=0 immediately. Then Op=Add, LV=5, RV=0xFFFFFFFF -> after 1 edge ALU_success=1 for 1 cycle, result=4.
- Signed vs unsigned compare: LV=0xFFFFFFFF, RV=1.
  - Op=Less -> result=1.
  - Op=LessU -> result=0.
  - Op=GEQU -> result=1.
- Iterative arithmetic shift: Op=RightShift_A, LV=0x80000000, RV=4 -> busy high for 4 cycles, ALU_success after 4th edge, result=0xF8000000. With ALU_BARREL_SHIFT_EN: after 1 edge.
- Zero shift amount: Op=LeftShift, LV=0x1234, RV=32 (shamt=0) -> 1-edge latency, result=0x1234.
- Busy/flush: Op=LeftShift, LV=1, RV=31.
  - Second request held during busy is not captured.
  - Assert flush on 10th SHIFT cycle -> no ALU_success; result unchanged; busy=0 next cycle.
  - Held request is then captured.
- rdy stall: drop rdy for 3 cycles during SHIFT with RV=3 -> state, cnt and acc frozen. ALU_success arrives 3 edges later than the unstalled case; pulse width stays exactly 1 rdy-high cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-issue ALU responder for the reservation-station dispatch port
// Optional macro ALU_BARREL_SHIFT_EN: one-cycle barrel shifts instead of the iterative SHIFT state.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            ALU_ready,
    input  logic [XLEN-1:0] LV,
    input  logic [XLEN-1:0] RV,
    input  logic [OP_W-1:0] Op,
    output logic            busy,
    output logic            ALU_success,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LT    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_GE    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_EQ    = OP_W'(10);
    localparam logic [OP_W-1:0] OP_NE    = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LTU   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_GEU   = OP_W'(13);

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] lv_q, lv_n;
    logic [XLEN-1:0] rv_q, rv_n;
    logic [OP_W-1:0] op_q, op_n;
    logic [XLEN-1:0] acc_q, acc_n;
    logic [SHW-1:0]  cnt_q, cnt_n;
    logic [XLEN-1:0] result_q, result_n;
    logic            success_q, success_n;

    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] acc_step;
    logic            req_is_shift;

    assign req_is_shift = (Op == OP_SLL) || (Op == OP_SRL) || (Op == OP_SRA);

    // Single-cycle datapath on the captured operands
    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD: alu_out = lv_q + rv_q;
            OP_SUB: alu_out = lv_q - rv_q;
            OP_AND: alu_out = lv_q & rv_q;
            OP_OR:  alu_out = lv_q | rv_q;
            OP_XOR: alu_out = lv_q ^ rv_q;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SLL: alu_out = lv_q << rv_q[SHW-1:0];
            OP_SRL: alu_out = lv_q >> rv_q[SHW-1:0];
            OP_SRA: alu_out = $signed(lv_q) >>> rv_q[SHW-1:0];
`else
            // Only a zero shift amount reaches COMPUTE in the iterative build
            OP_SLL, OP_SRL, OP_SRA: alu_out = lv_q;
`endif
            OP_LT:  alu_out = XLEN'($signed(lv_q) <  $signed(rv_q));
            OP_GE:  alu_out = XLEN'($signed(lv_q) >= $signed(rv_q));
            OP_EQ:  alu_out = XLEN'(lv_q == rv_q);
            OP_NE:  alu_out = XLEN'(lv_q != rv_q);
            OP_LTU: alu_out = XLEN'(lv_q <  rv_q);
            OP_GEU: alu_out = XLEN'(lv_q >= rv_q);
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
            OP_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_n   = state;
        lv_n      = lv_q;
        rv_n      = rv_q;
        op_n      = op_q;
        acc_n     = acc_q;
        cnt_n     = cnt_q;
        result_n  = result_q;
        success_n = success_q;
        if (rdy) begin
            success_n = 1'b0;
            if (flush) begin
                state_n = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (ALU_ready) begin
                            lv_n = LV;
                            rv_n = RV;
                            op_n = Op;
                            if (!BARREL && req_is_shift && (RV[SHW-1:0] != '0)) begin
                                state_n = SHIFT;
                                cnt_n   = RV[SHW-1:0];
                                acc_n   = LV;
                            end else begin
                                state_n = COMPUTE;
                            end
                        end
                    end
                    COMPUTE: begin
                        result_n  = alu_out;
                        success_n = 1'b1;
                        state_n   = IDLE;
                    end
                    SHIFT: begin
                        acc_n = acc_step;
                        cnt_n = cnt_q - SHW'(1);
                        if (cnt_q == SHW'(1)) begin
                            result_n  = acc_step;
                            success_n = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lv_q      <= '0;
            rv_q      <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            success_q <= 1'b0;
        end else begin
            state     <= state_n;
            lv_q      <= lv_n;
            rv_q      <= rv_n;
            op_q      <= op_n;
            acc_q     <= acc_n;
            cnt_q     <= cnt_n;
            result_q  <= result_n;
            success_q <= success_n;
        end
    end

    assign busy        = (state != IDLE);
    assign ALU_success = success_q;
    assign result      = result_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        ALU_ready;
    logic [31:0] LV;
    logic [31:0] RV;
    logic [3:0]  Op;
    logic        busy;
    logic        ALU_success;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    alu_exec_unit #(.XLEN(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ALU_ready(ALU_ready), .LV(LV), .RV(RV), .Op(Op),
        .busy(busy), .ALU_success(ALU_success), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int          s;
        logic [31:0] ones;
        logic [31:0] r;
        s    = int'(b[4:0]);
        ones = '1;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = a << s;
            6:  r = a >> s;
            7:  begin
                    r = a >> s;
                    if (a[31]) r = r | ~(ones >> s);
                end
            8:  r = ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            9:  r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            10: r = (a == b) ? 32'd1 : 32'd0;
            11: r = (a != b) ? 32'd1 : 32'd0;
            12: r = (a <  b) ? 32'd1 : 32'd0;
            13: r = (a >= b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input int op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (op >= 5 && op <= 7 && b[4:0] != 5'd0) return int'(b[4:0]);
        return 1;
`endif
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        @(negedge clk);
        Op = op; LV = a; RV = b; ALU_ready = 1'b1;
        @(posedge clk);
        #1 ALU_ready = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ALU_success) begin
                lat = i;
                break;
            end
        end
        res = result;
    endtask

    task automatic test_reset();
        int          lat;
        logic [31:0] res;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; ALU_ready = 1'b0;
        LV = '0; RV = '0; Op = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (ALU_success !== 1'b0) begin bad++; $display("FAIL reset_success: got %b want 0", ALU_success); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk) rst = 1'b0;
        run_op(4'd4, 32'hA5A5_0000, 32'h0000_5A5A, lat, res);
        total++; if (res !== 32'hA5A5_5A5A) begin bad++; $display("FAIL pre_reset_xor: got %h want a5a55a5a", res); end
        @(negedge clk);
        Op = 4'd5; LV = 32'd1; RV = 32'd31; ALU_ready = 1'b1;
        @(posedge clk);
        #1 ALU_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || ALU_success !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL midop_reset: got busy=%b succ=%b res=%h want 0 0 0", busy, ALU_success, result);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_add();
        int          lat;
        logic [31:0] res;
        run_op(4'd0, 32'd5, 32'hFFFF_FFFF, lat, res);
        total++; if (res !== 32'd4) begin bad++; $display("FAIL add_result: got %h want 4", res); end
        total++; if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
        @(posedge clk);
        #1;
        total++; if (ALU_success !== 1'b0) begin bad++; $display("FAIL add_pulse_width: got %b want 0", ALU_success); end
    endtask

    task automatic test_compare();
        logic [3:0]  ops [3] = '{4'd8, 4'd12, 4'd13};
        logic [31:0] want[3] = '{32'd1, 32'd0, 32'd1};
        int          lat;
        logic [31:0] res;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'hFFFF_FFFF, 32'd1, lat, res);
            total++; if (res !== want[i] || lat !== 1) begin
                bad++; $display("FAIL compare_op%0d: got res=%h lat=%0d want %h 1", ops[i], res, lat, want[i]);
            end
        end
    endtask

    task automatic test_arith_shift();
        int busy_cnt = 0;
        int lat = -1;
        int exp_lat;
        exp_lat = ref_lat(7, 32'd4);
        @(negedge clk);
        Op = 4'd7; LV = 32'h8000_0000; RV = 32'd4; ALU_ready = 1'b1;
        @(posedge clk);
        #1 ALU_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            if (ALU_success) begin lat = i; break; end
        end
        total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra_result: got %h want f8000000", result); end
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL sra_latency: got %0d want %0d", lat, exp_lat); end
        total++; if (busy_cnt !== exp_lat) begin bad++; $display("FAIL sra_busy_cycles: got %0d want %0d", busy_cnt, exp_lat); end
    endtask

    task automatic test_zero_shift();
        int          lat;
        logic [31:0] res;
        run_op(4'd5, 32'h1234, 32'd32, lat, res);
        total++; if (res !== 32'h1234 || lat !== 1) begin
            bad++; $display("FAIL zero_shift: got res=%h lat=%0d want 1234 1", res, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] edges[5] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1};
        int          lat;
        int          op;
        logic [31:0] a, b, res, want;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            if (n % 7 == 0) b = a;
            want = ref_alu(op, a, b);
            run_op(op[3:0], a, b, lat, res);
            total++; if (res !== want) begin
                bad++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h want %h", op, a, b, res, want);
            end
            total++; if (lat !== ref_lat(op, b)) begin
                bad++; $display("FAIL rand_latency op=%0d b=%h: got %0d want %0d", op, b, lat, ref_lat(op, b));
            end
        end
    endtask

    task automatic test_flush_busy();
        int          lat;
        int          fc;
        bit          ok = 1'b1;
        logic [31:0] res;
        run_op(4'd3, 32'hF0, 32'h0F, lat, res);
        total++; if (res !== 32'hFF) begin bad++; $display("FAIL flush_setup: got %h want ff", res); end
        fc = (ref_lat(5, 32'd31) >= 10) ? 10 : ref_lat(5, 32'd31);
        @(negedge clk);
        Op = 4'd5; LV = 32'd1; RV = 32'd31; ALU_ready = 1'b1;
        @(posedge clk);
        #1;
        Op = 4'd0; LV = 32'd7; RV = 32'd8;
        for (int i = 1; i < fc; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || ALU_success !== 1'b0 || result !== 32'hFF) ok = 1'b0;
        end
        total++; if (!ok) begin bad++; $display("FAIL held_request_ignored: got early change want busy shift"); end
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        total++; if (busy !== 1'b0 || ALU_success !== 1'b0 || result !== 32'hFF) begin
            bad++; $display("FAIL flush_kill: got busy=%b succ=%b res=%h want 0 0 ff", busy, ALU_success, result);
        end
        @(posedge clk);
        #1 ALU_ready = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_capture_busy: got %b want 1", busy); end
        @(posedge clk);
        #1;
        total++; if (ALU_success !== 1'b1 || result !== 32'd15) begin
            bad++; $display("FAIL held_capture_result: got succ=%b res=%h want 1 f", ALU_success, result);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        int          lat = -1;
        int          exp_lat;
        bit          ok = 1'b1;
        a = $urandom;
        exp_lat = ref_lat(6, 32'd3) + 3;
        @(negedge clk);
        Op = 4'd6; LV = a; RV = 32'd3; ALU_ready = 1'b1;
        @(posedge clk);
        #1 ALU_ready = 1'b0; rdy = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (ALU_success) begin lat = i; break; end
            if (i <= 3 && busy !== 1'b1) ok = 1'b0;
            if (i == 3) rdy = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL stall_busy: got busy drop want held"); end
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL stall_latency: got %0d want %0d", lat, exp_lat); end
        total++; if (result !== ref_alu(6, a, 32'd3)) begin
            bad++; $display("FAIL stall_result: got %h want %h", result, ref_alu(6, a, 32'd3));
        end
        rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (ALU_success !== 1'b1) begin bad++; $display("FAIL stall_pulse_hold: got %b want 1", ALU_success); end
        rdy = 1'b1;
        @(posedge clk);
        #1;
        total++; if (ALU_success !== 1'b0) begin bad++; $display("FAIL stall_pulse_end: got %b want 0", ALU_success); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_compare();
        test_arith_shift();
        test_zero_shift();
        test_random();
        test_flush_busy();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
